// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: instruction
// field constants, ALU control encodings, datapath selector encodings,
// the FSM state enumeration and a helper classifying memory states.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // 3-bit ALU control encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alu_src_b selector
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pc_src selector
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Request to the ALU decoder: fixed ADD, fixed SUB, or decode funct
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_ALUWB  = 4'd3,
    ST_ADDIEX = 4'd4,
    ST_ADDIWB = 4'd5,
    ST_MEMADR = 4'd6,
    ST_MEMRD  = 4'd7,
    ST_MEMWB  = 4'd8,
    ST_MEMWR  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_FAULT  = 4'd12
  } state_e;

  // States that hold a memory access open until mem_ready
  function automatic logic is_mem_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle control unit and its datapath.
// Inputs to the controller: opcode/funct from the IR, mem_ready from memory.
// Outputs: memory request/strobes, IR/PC/regfile write enables, datapath
// mux selects, ALU control, the sticky fault flag and a state debug view.
// master = control unit, slave = datapath/memory side.
interface mips_multicycle_control_if #(
  parameter int ALUCTL_W = 3
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                mem_ready;
  logic                mem_req;
  logic                iord;
  logic                mem_write;
  logic                ir_write;
  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUCTL_W-1:0] alu_ctl;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                fault;
  logic [3:0]          state_dbg;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_ctl, reg_dst, mem_to_reg,
           reg_write, fault, state_dbg
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_ctl, reg_dst, mem_to_reg,
           reg_write, fault, state_dbg
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder.
// Ports: alu_op (fixed ADD / fixed SUB / decode funct), funct (IR[5:0]),
// alu_ctl (3-bit ALU operation), funct_illegal (unsupported funct while
// alu_op asks for funct decoding).
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       funct_illegal
);

  always_comb begin
    alu_ctl       = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      AOP_SUB: alu_ctl = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: sequences R-type, ADDI, LW, SW, BEQ and J
// through a Moore FSM, with a variable-latency memory handshake, a per-access
// wait-state timeout and an absorbing fault state for illegal encodings.
// Ports: clk, reset (async, active-high), ctrl (master side of the control
// bus: IR fields and mem_ready in, datapath/memory controls out).
// ALUCTL_W must match the interface parameter; CNT_W must hold MEM_TIMEOUT.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTL_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  ctrl
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  alu_op_e          alu_op;
  logic [2:0]       alu_ctl3;
  logic             funct_illegal;
  logic             mem_wait;
  logic             timeout_hit;

  mips_alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (ctrl.funct),
    .alu_ctl       (alu_ctl3),
    .funct_illegal (funct_illegal)
  );

  assign ctrl.alu_ctl   = ALUCTL_W'(alu_ctl3);
  assign ctrl.state_dbg = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Non-memory states force the counter to zero, so every memory state is
  // entered with a fresh count. timeout_hit fires on the cycle whose
  // increment would reach MEM_TIMEOUT; mem_ready in that cycle still wins.
  always_comb begin
    mem_wait    = is_mem_state(state_q) && !ctrl.mem_ready;
    wait_d      = mem_wait ? (wait_q + CNT_W'(1)) : '0;
    timeout_hit = mem_wait && (MEM_TIMEOUT != 0) &&
                  ((wait_q + CNT_W'(1)) == TIMEOUT_CNT);
  end

  // Kept separate from the main FSM block so the decoder's funct_illegal
  // feedback does not form a combinational loop through one process.
  always_comb begin
    case (state_q)
      ST_EXEC:   alu_op = AOP_FUNCT;
      ST_BRANCH: alu_op = AOP_SUB;
      default:   alu_op = AOP_ADD;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    ctrl.mem_req       = 1'b0;
    ctrl.iord          = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.pc_src        = PCSRC_ALU;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = SRCB_RT;
    ctrl.reg_dst       = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.fault         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        if (ctrl.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (ctrl.opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        state_d        = funct_illegal ? ST_FAULT : ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (ctrl.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (ctrl.mem_ready)   state_d = ST_MEMWB;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (ctrl.mem_ready)   state_d = ST_FETCH;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        state_d            = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_FAULT: begin
        ctrl.fault = 1'b1;
        state_d    = ST_FAULT;
      end
      default: state_d = ST_FAULT;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control: walks each
// instruction class through its state sequence and checks the Moore
// outputs, the illegal opcode/funct trap, the memory timeout boundary and
// asynchronous reset during a store.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  int   regWriteCount;

  mips_multicycle_control_if #(.ALUCTL_W(3)) bus ();

  mips_multicycle_control #(
    .ALUCTL_W    (3),
    .MEM_TIMEOUT (16),
    .CNT_W       (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts register-file write cycles, sampled mid-cycle
  always @(negedge clk) if (bus.reg_write === 1'b1) regWriteCount++;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic expectState(input string tag, input state_e s);
    checkOutput(tag, 32'(bus.state_dbg), 32'(s));
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic rdy);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    expectState("rst_state", ST_FETCH);
    checkOutput("rst_fault", 32'(bus.fault), 32'd0);
    reset = 1'b0;
  endtask

  logic [5:0] fnTab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] ctlTab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  initial begin
    int startWrites;
    checkCount    = 0;
    errorCount    = 0;
    regWriteCount = 0;
    reset         = 1'b1;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.mem_ready = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    expectState("reset_state", ST_FETCH);
    checkOutput("reset_fault", 32'(bus.fault), 32'd0);
    checkOutput("reset_mem_req", 32'(bus.mem_req), 32'd1);
    checkOutput("reset_ir_write", 32'(bus.ir_write), 32'd0);

    // R-type, one pass per supported funct
    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'b000000, fnTab[i], 1'b1);
      expectState("rt_fetch", ST_FETCH);
      checkOutput("rt_fetch_irw", 32'(bus.ir_write), 32'd1);
      checkOutput("rt_fetch_pcw", 32'(bus.pc_write), 32'd1);
      checkOutput("rt_fetch_srcb", 32'(bus.alu_src_b), 32'd1);
      nextCycle();
      applyStimulus(6'b000000, fnTab[i], 1'b1);
      expectState("rt_decode", ST_DECODE);
      checkOutput("rt_decode_srcb", 32'(bus.alu_src_b), 32'd3);
      checkOutput("rt_decode_irw", 32'(bus.ir_write), 32'd0);
      nextCycle();
      applyStimulus(6'b000000, fnTab[i], 1'b1);
      expectState("rt_exec", ST_EXEC);
      checkOutput("rt_exec_aluctl", 32'(bus.alu_ctl), 32'(ctlTab[i]));
      checkOutput("rt_exec_srca", 32'(bus.alu_src_a), 32'd1);
      checkOutput("rt_exec_srcb", 32'(bus.alu_src_b), 32'd0);
      nextCycle();
      applyStimulus(6'b000000, fnTab[i], 1'b1);
      expectState("rt_aluwb", ST_ALUWB);
      checkOutput("rt_aluwb_regw", 32'(bus.reg_write), 32'd1);
      checkOutput("rt_aluwb_regdst", 32'(bus.reg_dst), 32'd1);
      nextCycle();
    end

    // ADDI
    applyStimulus(6'b001000, 6'd0, 1'b1);
    expectState("addi_fetch", ST_FETCH);
    nextCycle();
    applyStimulus(6'b001000, 6'd0, 1'b1);
    expectState("addi_decode", ST_DECODE);
    nextCycle();
    applyStimulus(6'b001000, 6'd0, 1'b1);
    expectState("addi_ex", ST_ADDIEX);
    checkOutput("addi_ex_srcb", 32'(bus.alu_src_b), 32'd2);
    checkOutput("addi_ex_aluctl", 32'(bus.alu_ctl), 32'b010);
    nextCycle();
    applyStimulus(6'b001000, 6'd0, 1'b1);
    expectState("addi_wb", ST_ADDIWB);
    checkOutput("addi_wb_regw", 32'(bus.reg_write), 32'd1);
    checkOutput("addi_wb_regdst", 32'(bus.reg_dst), 32'd0);
    nextCycle();

    // LW with three wait cycles in MEMRD
    startWrites = regWriteCount;
    applyStimulus(6'b100011, 6'd0, 1'b1);
    expectState("lw_fetch", ST_FETCH);
    nextCycle();
    applyStimulus(6'b100011, 6'd0, 1'b1);
    expectState("lw_decode", ST_DECODE);
    nextCycle();
    applyStimulus(6'b100011, 6'd0, 1'b1);
    expectState("lw_memadr", ST_MEMADR);
    checkOutput("lw_memadr_srcb", 32'(bus.alu_src_b), 32'd2);
    checkOutput("lw_memadr_req", 32'(bus.mem_req), 32'd0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(6'b100011, 6'd0, (k == 3));
      expectState("lw_memrd", ST_MEMRD);
      checkOutput("lw_memrd_req", 32'(bus.mem_req), 32'd1);
      checkOutput("lw_memrd_iord", 32'(bus.iord), 32'd1);
      checkOutput("lw_memrd_regw", 32'(bus.reg_write), 32'd0);
      nextCycle();
    end
    applyStimulus(6'b100011, 6'd0, 1'b1);
    expectState("lw_memwb", ST_MEMWB);
    checkOutput("lw_memwb_regw", 32'(bus.reg_write), 32'd1);
    checkOutput("lw_memwb_m2r", 32'(bus.mem_to_reg), 32'd1);
    checkOutput("lw_memwb_regdst", 32'(bus.reg_dst), 32'd0);
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b1);
    expectState("lw_done", ST_FETCH);
    checkOutput("lw_write_count", 32'(regWriteCount - startWrites), 32'd1);

    // SW
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b1);
    expectState("sw_decode", ST_DECODE);
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b1);
    expectState("sw_memadr", ST_MEMADR);
    checkOutput("sw_memadr_mw", 32'(bus.mem_write), 32'd0);
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b1);
    expectState("sw_memwr", ST_MEMWR);
    checkOutput("sw_memwr_mw", 32'(bus.mem_write), 32'd1);
    checkOutput("sw_memwr_req", 32'(bus.mem_req), 32'd1);
    checkOutput("sw_memwr_iord", 32'(bus.iord), 32'd1);
    nextCycle();
    applyStimulus(6'b000100, 6'd0, 1'b1);
    expectState("sw_done", ST_FETCH);
    checkOutput("sw_done_mw", 32'(bus.mem_write), 32'd0);

    // BEQ
    nextCycle();
    applyStimulus(6'b000100, 6'd0, 1'b1);
    expectState("beq_decode", ST_DECODE);
    nextCycle();
    applyStimulus(6'b000100, 6'd0, 1'b1);
    expectState("beq_branch", ST_BRANCH);
    checkOutput("beq_aluctl", 32'(bus.alu_ctl), 32'b110);
    checkOutput("beq_pcwc", 32'(bus.pc_write_cond), 32'd1);
    checkOutput("beq_pcsrc", 32'(bus.pc_src), 32'd1);
    checkOutput("beq_pcw", 32'(bus.pc_write), 32'd0);
    nextCycle();
    applyStimulus(6'b000010, 6'd0, 1'b1);
    expectState("beq_done", ST_FETCH);

    // J
    nextCycle();
    applyStimulus(6'b000010, 6'd0, 1'b1);
    expectState("j_decode", ST_DECODE);
    nextCycle();
    applyStimulus(6'b000010, 6'd0, 1'b1);
    expectState("j_jump", ST_JUMP);
    checkOutput("j_pcsrc", 32'(bus.pc_src), 32'd2);
    checkOutput("j_pcw", 32'(bus.pc_write), 32'd1);
    nextCycle();
    applyStimulus(6'b111111, 6'd0, 1'b1);
    expectState("j_done", ST_FETCH);

    // Illegal opcode traps and stays trapped
    nextCycle();
    applyStimulus(6'b111111, 6'd0, 1'b1);
    expectState("badop_decode", ST_DECODE);
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(6'b000000, 6'b100000, 1'b1);
      expectState("badop_fault", ST_FAULT);
      checkOutput("badop_fault_flag", 32'(bus.fault), 32'd1);
      checkOutput("badop_writes", 32'({bus.mem_req, bus.mem_write, bus.ir_write,
                  bus.pc_write, bus.pc_write_cond, bus.reg_write}), 32'd0);
      nextCycle();
    end
    doReset();

    // Illegal funct traps from EXEC
    applyStimulus(6'b000000, 6'b000111, 1'b1);
    nextCycle();
    applyStimulus(6'b000000, 6'b000111, 1'b1);
    expectState("badfn_decode", ST_DECODE);
    nextCycle();
    applyStimulus(6'b000000, 6'b000111, 1'b1);
    expectState("badfn_exec", ST_EXEC);
    nextCycle();
    applyStimulus(6'b000000, 6'b000111, 1'b1);
    expectState("badfn_fault", ST_FAULT);
    checkOutput("badfn_fault_flag", 32'(bus.fault), 32'd1);
    doReset();

    // Fetch timeout: 16 waiting cycles then FAULT
    for (int k = 0; k < 16; k++) begin
      applyStimulus(6'd0, 6'd0, 1'b0);
      expectState("tmo_wait", ST_FETCH);
      nextCycle();
    end
    applyStimulus(6'd0, 6'd0, 1'b0);
    expectState("tmo_fault", ST_FAULT);
    checkOutput("tmo_fault_flag", 32'(bus.fault), 32'd1);
    doReset();

    // mem_ready on the 16th waiting cycle completes the fetch
    for (int k = 0; k < 15; k++) begin
      applyStimulus(6'd0, 6'd0, 1'b0);
      nextCycle();
    end
    applyStimulus(6'd0, 6'd0, 1'b1);
    expectState("tmo_edge_fetch", ST_FETCH);
    checkOutput("tmo_edge_irw", 32'(bus.ir_write), 32'd1);
    nextCycle();
    applyStimulus(6'd0, 6'd0, 1'b1);
    expectState("tmo_edge_decode", ST_DECODE);
    doReset();

    // Asynchronous reset while a store is stalled
    applyStimulus(6'b101011, 6'd0, 1'b1);
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b1);
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b0);
    expectState("rstwr_memadr", ST_MEMADR);
    nextCycle();
    applyStimulus(6'b101011, 6'd0, 1'b0);
    expectState("rstwr_memwr", ST_MEMWR);
    checkOutput("rstwr_mw_before", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstwr_mw_after", 32'(bus.mem_write), 32'd0);
    expectState("rstwr_state", ST_FETCH);
    reset = 1'b0;
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
